// File: rtl/bist_pkg.sv
// Shared types and MISR update for the BIST response compactor.
// The next-state function is used by the register and by any reference model.
package bist_pkg;

  localparam int             DEF_IN_WIDTH  = 2;
  localparam int             DEF_SIG_WIDTH = 8;
  localparam logic [7:0]     DEF_POLY      = 8'h1D;
  localparam logic [7:0]     DEF_SEED      = 8'h00;
  localparam int             MISR_MAX_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Galois MISR step on a 32-bit container; bits at or above width are cleared.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] resp,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] nxt;
    mask = (width >= MISR_MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
    nxt  = (sig << 1) ^ (sig[5'(width - 1)] ? poly : '0) ^ resp;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: load takes SEED, enable absorbs one response per clock.
// Update is visible one clock after the edge; no backpressure, load wins over enable.
module misr_reg
  import bist_pkg::*;
#(
  parameter int                   IN_WIDTH  = DEF_IN_WIDTH,
  parameter int                   SIG_WIDTH = DEF_SIG_WIDTH,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEF_POLY),
  parameter logic [SIG_WIDTH-1:0] SEED      = SIG_WIDTH'(DEF_SEED)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [IN_WIDTH-1:0]  i_resp,
  output logic [SIG_WIDTH-1:0] o_sig
);

  logic [SIG_WIDTH-1:0]  r_sig;
  logic [MISR_MAX_W-1:0] w_next_full;
  logic [SIG_WIDTH-1:0]  w_next;

  always_comb begin
    w_next_full = misr_next(MISR_MAX_W'(r_sig), MISR_MAX_W'(i_resp),
                            MISR_MAX_W'(POLY), SIG_WIDTH);
    w_next      = w_next_full[SIG_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/bist_misr_compactor.sv
// BIST response compactor: absorbs PATTERN_COUNT responses after start, then compares to GOLDEN.
// done/pass appear PATTERN_COUNT+1 edges after the start edge; no backpressure, start ignored while busy.
module bist_misr_compactor
  import bist_pkg::*;
#(
  parameter int                   IN_WIDTH      = DEF_IN_WIDTH,
  parameter int                   SIG_WIDTH     = DEF_SIG_WIDTH,
  parameter logic [SIG_WIDTH-1:0] POLY          = SIG_WIDTH'(DEF_POLY),
  parameter logic [SIG_WIDTH-1:0] SEED          = SIG_WIDTH'(DEF_SEED),
  parameter int                   PATTERN_COUNT = 31,
  parameter logic [SIG_WIDTH-1:0] GOLDEN        = '0,
  localparam int                  CNT_W         = $clog2(PATTERN_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  resp_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [CNT_W-1:0]     pat_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERN_COUNT - 1);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_load;
  logic                 w_absorb;
  logic [SIG_WIDTH-1:0] w_sig;

  // A session may only be (re)launched from IDLE or DONE.
  assign w_load   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_absorb = (r_state == RUN);

  misr_reg #(
    .IN_WIDTH (IN_WIDTH),
    .SIG_WIDTH(SIG_WIDTH),
    .POLY     (POLY),
    .SEED     (SEED)
  ) u_misr (
    .clk   (clk),
    .rst   (reset),
    .i_load(w_load),
    .i_en  (w_absorb),
    .i_resp(resp_in),
    .o_sig (w_sig)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= CMP;
          end
        end
        CMP: begin
          r_pass  <= (w_sig == GOLDEN);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end
        DONE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = w_sig;
  assign pat_cnt   = r_cnt;

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Directed bench: five compactor instances share one stimulus stream, each checked where its parameters matter.
module tb_bist_misr_compactor;
  import bist_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] resp_in;

  always #5 clk = ~clk;

  // a: PC=4 GOLDEN=00, b: PC=4 GOLDEN=11, c: PC=4 GOLDEN=12, d: PC=9 GOLDEN=1D, e: PC=31 GOLDEN=00
  logic a_busy, a_done, a_pass; logic [7:0] a_sig; logic [2:0] a_cnt;
  logic b_busy, b_done, b_pass; logic [7:0] b_sig; logic [2:0] b_cnt;
  logic c_busy, c_done, c_pass; logic [7:0] c_sig; logic [2:0] c_cnt;
  logic d_busy, d_done, d_pass; logic [7:0] d_sig; logic [3:0] d_cnt;
  logic e_busy, e_done, e_pass; logic [7:0] e_sig; logic [4:0] e_cnt;

  bist_misr_compactor #(.PATTERN_COUNT(4), .GOLDEN(8'h00)) u_a (
    .clk(clk), .reset(reset), .start(start), .resp_in(resp_in),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .pat_cnt(a_cnt));
  bist_misr_compactor #(.PATTERN_COUNT(4), .GOLDEN(8'h11)) u_b (
    .clk(clk), .reset(reset), .start(start), .resp_in(resp_in),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .pat_cnt(b_cnt));
  bist_misr_compactor #(.PATTERN_COUNT(4), .GOLDEN(8'h12)) u_c (
    .clk(clk), .reset(reset), .start(start), .resp_in(resp_in),
    .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig), .pat_cnt(c_cnt));
  bist_misr_compactor #(.PATTERN_COUNT(9), .GOLDEN(8'h1D)) u_d (
    .clk(clk), .reset(reset), .start(start), .resp_in(resp_in),
    .busy(d_busy), .done(d_done), .pass(d_pass), .signature(d_sig), .pat_cnt(d_cnt));
  bist_misr_compactor #(.PATTERN_COUNT(31), .GOLDEN(8'h00)) u_e (
    .clk(clk), .reset(reset), .start(start), .resp_in(resp_in),
    .busy(e_busy), .done(e_done), .pass(e_pass), .signature(e_sig), .pat_cnt(e_cnt));

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  function automatic logic [4:0] lfsr_step(input logic [4:0] v);
    return {v[3:0], ~(v[4] ^ v[2])};
  endfunction

  // c17 benchmark: inputs N1,N2,N3,N6,N7 from LFSR bits 0..4, outputs {N22,N23}.
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[0] & v[2]);
    n11 = ~(v[2] & v[3]);
    n16 = ~(v[1] & n11);
    n19 = ~(n11 & v[4]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  logic [1:0]  live [31];
  logic [7:0]  live_sig;
  logic [7:0]  const_exp [4];
  logic [31:0] step;

  initial begin
    logic [4:0] v;
    reset   = 1'b1;
    start   = 1'b0;
    resp_in = 2'b00;

    v        = 5'd0;
    live_sig = 8'h00;
    for (int i = 0; i < 31; i++) begin
      live[i]  = c17(v);
      step     = misr_next(32'(live_sig), 32'(live[i]), 32'h1D, 8);
      live_sig = step[7:0];
      v        = lfsr_step(v);
    end
    const_exp[0] = 8'h03; const_exp[1] = 8'h05;
    const_exp[2] = 8'h09; const_exp[3] = 8'h11;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sig",  32'(e_sig),  32'h0);
    chk("rst_cnt",  32'(e_cnt),  32'h0);
    chk("rst_busy", 32'(e_busy), 32'h0);
    chk("rst_done", 32'(e_done), 32'h0);
    chk("rst_pass", 32'(e_pass), 32'h0);
    reset = 1'b0;

    // Zero response, PC=4
    start = 1'b1; tick(); start = 1'b0;
    chk("zero_busy", 32'(a_busy), 32'h1);
    repeat (4) tick();
    chk("zero_cnt",      32'(a_cnt),  32'h4);
    chk("zero_not_done", 32'(a_done), 32'h0);
    tick();
    chk("zero_done", 32'(a_done), 32'h1);
    chk("zero_pass", 32'(a_pass), 32'h1);
    chk("zero_sig",  32'(a_sig),  32'h0);
    chk("zero_idle", 32'(a_busy), 32'h0);

    // Constant response 2'b11, PC=4
    pulse_reset();
    start = 1'b1; tick(); start = 1'b0;
    resp_in = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("const_sig%0d", i), 32'(b_sig), 32'(const_exp[i]));
    end
    tick();
    chk("const_pass_g11", 32'(b_pass), 32'h1);
    chk("const_pass_g12", 32'(c_pass), 32'h0);
    chk("const_done_g12", 32'(c_done), 32'h1);
    tick();
    chk("const_hold_sig", 32'(b_sig), 32'h11);
    chk("const_hold_cnt", 32'(b_cnt), 32'h4);

    // Feedback wrap, PC=9
    pulse_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      resp_in = (i == 0) ? 2'b01 : 2'b00;
      tick();
      if (i == 7) chk("wrap_sig80", 32'(d_sig), 32'h80);
    end
    chk("wrap_sig1d", 32'(d_sig), 32'h1D);
    chk("wrap_cnt",   32'(d_cnt), 32'h9);
    tick();
    chk("wrap_done", 32'(d_done), 32'h1);
    chk("wrap_pass", 32'(d_pass), 32'h1);

    // Reset in the middle of a 31-pattern session
    pulse_reset();
    start = 1'b1; tick(); start = 1'b0;
    resp_in = 2'b11;
    repeat (3) tick();
    chk("mid_cnt3", 32'(e_cnt), 32'h3);
    chk("mid_sig",  32'(e_sig), 32'h09);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_sig",  32'(e_sig),  32'h0);
    chk("mid_rst_cnt",  32'(e_cnt),  32'h0);
    chk("mid_rst_busy", 32'(e_busy), 32'h0);
    reset = 1'b0;

    // Live LFSR+c17 chain, with a start pulse mid-run that must be ignored
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      start   = (i == 10);
      resp_in = live[i];
      tick();
      if (i == 10) chk("ign_cnt", 32'(e_cnt), 32'd11);
    end
    chk("live_cnt",  32'(e_cnt),  32'd31);
    chk("live_sig",  32'(e_sig),  32'(live_sig));
    chk("live_busy", 32'(e_busy), 32'h1);
    // Start held through CMP (ignored) and into DONE (restart)
    start = 1'b1;
    tick();
    chk("live_done", 32'(e_done), 32'h1);
    chk("live_pass", 32'(e_pass), 32'(live_sig == 8'h00));
    chk("cmp_hold",  32'(e_sig),  32'(live_sig));
    tick();
    start = 1'b0;
    chk("re_done", 32'(e_done), 32'h0);
    chk("re_pass", 32'(e_pass), 32'h0);
    chk("re_seed", 32'(e_sig),  32'h0);
    chk("re_cnt",  32'(e_cnt),  32'h0);
    chk("re_busy", 32'(e_busy), 32'h1);
    for (int i = 0; i < 31; i++) begin
      resp_in = live[i];
      tick();
    end
    chk("rerun_sig", 32'(e_sig), 32'(live_sig));
    tick();
    chk("rerun_done", 32'(e_done), 32'h1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
